// File: rtl/hls_stream_fifo_thr.sv
// hls_stream_fifo_thr
// Parametrised show-ahead stream FIFO for HLS dataflow channels. Storage is a
// DEPTH-entry register array addressed by circular pointers that wrap at
// DEPTH-1 (so non-power-of-2 depths work). The occupancy counter and all
// status flags are registered; the almost-full/almost-empty flags are
// computed from the next-state occupancy so they change on the same edge
// as if_num_data_valid.
//
// Optional build macro: HLS_STREAM_FIFO_ERR_FLAGS_EN
//   When defined, adds sticky overflow/underflow error flags with a clear.
//
// Ports:
//   clk               in   clock, rising edge
//   reset             in   synchronous, active-high
//   if_din            in   write data [DATA_WIDTH]
//   if_write          in   write request
//   if_write_ce       in   write clock-enable (attempt = if_write & if_write_ce)
//   if_full_n         out  1 = space available
//   if_read           in   read request
//   if_read_ce        in   read clock-enable (attempt = if_read & if_read_ce)
//   if_empty_n        out  1 = data available
//   if_dout           out  head-of-queue data (valid while if_empty_n = 1)
//   if_num_data_valid out  current occupancy [ADDR_WIDTH+1]
//   if_fifo_cap       out  constant DEPTH [ADDR_WIDTH+1]
//   if_almost_full    out  registered, occupancy >= AF_LEVEL
//   if_almost_empty   out  registered, occupancy <= AE_LEVEL
//   if_err_clr        in   (macro only) clears sticky error flags
//   if_overflow       out  (macro only) sticky: write attempted while full
//   if_underflow      out  (macro only) sticky: read attempted while empty
module hls_stream_fifo_thr #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 5,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  output logic                  if_full_n,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic                  if_empty_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap,
  output logic                  if_almost_full,
`ifdef HLS_STREAM_FIFO_ERR_FLAGS_EN
  output logic                  if_almost_empty,
  input  logic                  if_err_clr,
  output logic                  if_overflow,
  output logic                  if_underflow
`else
  output logic                  if_almost_empty
`endif
);

  localparam logic [ADDR_WIDTH-1:0] C_LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   C_DEPTH    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   C_AF_LEVEL = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   C_AE_LEVEL = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic                  C_AF_RESET = (AF_LEVEL == 0);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_full_n;
  logic                  r_empty_n;
  logic                  r_almost_full;
  logic                  r_almost_empty;

  logic                  w_wr_try;
  logic                  w_rd_try;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [ADDR_WIDTH-1:0] w_wr_ptr_inc;
  logic [ADDR_WIDTH-1:0] w_rd_ptr_inc;
  logic [ADDR_WIDTH:0]   w_cnt_next;
  logic                  w_full_n_next;
  logic                  w_empty_n_next;

  assign w_wr_try = if_write & if_write_ce;
  assign w_rd_try = if_read & if_read_ce;
  assign w_wr_acc = w_wr_try & r_full_n;
  assign w_rd_acc = w_rd_try & r_empty_n;

  // Explicit wrap at DEPTH-1 rather than natural 2^N rollover.
  assign w_wr_ptr_inc = (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_inc = (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

  // Simultaneous accept leaves occupancy and full/empty flags untouched.
  always_comb begin
    w_cnt_next     = r_cnt;
    w_full_n_next  = r_full_n;
    w_empty_n_next = r_empty_n;
    case ({w_wr_acc, w_rd_acc})
      2'b10: begin
        w_cnt_next     = r_cnt + 1'b1;
        w_empty_n_next = 1'b1;
        w_full_n_next  = ((r_cnt + 1'b1) != C_DEPTH);
      end
      2'b01: begin
        w_cnt_next     = r_cnt - 1'b1;
        w_full_n_next  = 1'b1;
        w_empty_n_next = ((r_cnt - 1'b1) != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_cnt          <= '0;
      r_full_n       <= 1'b1;
      r_empty_n      <= 1'b0;
      r_almost_full  <= C_AF_RESET;
      r_almost_empty <= 1'b1;
    end else begin
      if (w_wr_acc) r_wr_ptr <= w_wr_ptr_inc;
      if (w_rd_acc) r_rd_ptr <= w_rd_ptr_inc;
      r_cnt          <= w_cnt_next;
      r_full_n       <= w_full_n_next;
      r_empty_n      <= w_empty_n_next;
      r_almost_full  <= (w_cnt_next >= C_AF_LEVEL);
      r_almost_empty <= (w_cnt_next <= C_AE_LEVEL);
    end
  end

  // Array contents are deliberately not reset; a write during reset is
  // harmless because the pointers and count are cleared on the same edge.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= if_din;
  end

  assign if_dout           = r_mem[r_rd_ptr];
  assign if_full_n         = r_full_n;
  assign if_empty_n        = r_empty_n;
  assign if_num_data_valid = r_cnt;
  assign if_fifo_cap       = C_DEPTH;
  assign if_almost_full    = r_almost_full;
  assign if_almost_empty   = r_almost_empty;

`ifdef HLS_STREAM_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;
  logic w_ovf_set;
  logic w_udf_set;

  // A refused write only counts as overflow if no read drains the FIFO in
  // the same cycle.
  assign w_ovf_set = w_wr_try & ~r_full_n & ~w_rd_acc;
  assign w_udf_set = w_rd_try & ~r_empty_n;

  // Set has priority over the clear input; reset overrides both.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)       r_overflow <= 1'b1;
      else if (if_err_clr) r_overflow <= 1'b0;
      if (w_udf_set)       r_underflow <= 1'b1;
      else if (if_err_clr) r_underflow <= 1'b0;
    end
  end

  assign if_overflow  = r_overflow;
  assign if_underflow = r_underflow;
`endif

endmodule

// File: tb/tb_hls_stream_fifo_thr.sv
// Directed testbench for hls_stream_fifo_thr with DEPTH=5, AF_LEVEL=4,
// AE_LEVEL=1. A queue holds the expected contents; acceptance is decided
// from the expected occupancy, never from DUT outputs.
module tb_hls_stream_fifo_thr;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] if_din = '0;
  logic       if_write = 1'b0;
  logic       if_write_ce = 1'b0;
  logic       if_full_n;
  logic       if_read = 1'b0;
  logic       if_read_ce = 1'b0;
  logic       if_empty_n;
  logic [7:0] if_dout;
  logic [3:0] if_num_data_valid;
  logic [3:0] if_fifo_cap;
  logic       if_almost_full;
  logic       if_almost_empty;
`ifdef HLS_STREAM_FIFO_ERR_FLAGS_EN
  logic       if_err_clr = 1'b0;
  logic       if_overflow;
  logic       if_underflow;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q[$];
  int m_cnt = 0;

  always #5 clk = ~clk;

  hls_stream_fifo_thr #(
    .DATA_WIDTH(8),
    .DEPTH(5)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .if_din           (if_din),
    .if_write         (if_write),
    .if_write_ce      (if_write_ce),
    .if_full_n        (if_full_n),
    .if_read          (if_read),
    .if_read_ce       (if_read_ce),
    .if_empty_n       (if_empty_n),
    .if_dout          (if_dout),
    .if_num_data_valid(if_num_data_valid),
    .if_fifo_cap      (if_fifo_cap),
    .if_almost_full   (if_almost_full),
`ifdef HLS_STREAM_FIFO_ERR_FLAGS_EN
    .if_almost_empty  (if_almost_empty),
    .if_err_clr       (if_err_clr),
    .if_overflow      (if_overflow),
    .if_underflow     (if_underflow)
`else
    .if_almost_empty  (if_almost_empty)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every status output against the expected occupancy.
  task automatic chk_status(input string tag);
    chk({tag, ".ndv"},     32'(if_num_data_valid), 32'(m_cnt));
    chk({tag, ".full_n"},  32'(if_full_n),         32'(m_cnt != 5));
    chk({tag, ".empty_n"}, 32'(if_empty_n),        32'(m_cnt != 0));
    chk({tag, ".af"},      32'(if_almost_full),    32'(m_cnt >= 4));
    chk({tag, ".ae"},      32'(if_almost_empty),   32'(m_cnt <= 1));
  endtask

  // One clock with the given requests; ce held high. Head data is checked
  // before the edge whenever a read is expected to be accepted.
  task automatic cycle(input string tag, input logic wr, input logic rd, input logic [7:0] din);
    logic wa, ra;
    wa = wr && (m_cnt < 5);
    ra = rd && (m_cnt > 0);
    if_din = din; if_write = wr; if_read = rd;
    if_write_ce = 1'b1; if_read_ce = 1'b1;
    #1;
    if (ra) chk({tag, ".dout"}, 32'(if_dout), 32'(q[0]));
    tick();
    if_write = 1'b0; if_read = 1'b0;
    if (ra) void'(q.pop_front());
    if (wa) q.push_back(din);
    m_cnt = q.size();
    chk_status(tag);
    $display("%s: wr=%0b rd=%0b din=0x%02h -> ndv=%0d full_n=%0b empty_n=%0b",
             tag, wr, rd, din, if_num_data_valid, if_full_n, if_empty_n);
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_status("reset");
    chk("reset.cap", 32'(if_fifo_cap), 32'd5);

    // Fill: almost_full after 4th write, full after 5th, 6th dropped.
    for (int i = 0; i < 5; i++) cycle("fill", 1'b1, 1'b0, 8'(8'h11 * (i + 1)));
    chk("fill.af_hand", 32'(if_almost_full), 32'd1);
    cycle("overwrite", 1'b1, 1'b0, 8'h66);
    chk("overwrite.ndv_hand", 32'(if_num_data_valid), 32'd5);

    // Drain: 0x11..0x55 in order.
    for (int i = 0; i < 5; i++) cycle("drain", 1'b0, 1'b1, 8'h00);
    chk("drain.empty_hand", 32'(if_empty_n), 32'd0);

    // Clock-enables gate the request.
    if_write = 1'b1; if_write_ce = 1'b0; if_din = 8'h77;
    tick();
    if_write = 1'b0;
    chk("wr_ce_gate.ndv", 32'(if_num_data_valid), 32'd0);

    // Wrap stress at occupancy 3.
    for (int i = 0; i < 3; i++) cycle("pre", 1'b1, 1'b0, 8'(8'hA0 + i));
    for (int i = 0; i < 20; i++) cycle("wrap", 1'b1, 1'b1, 8'(8'hA3 + i));
    chk("wrap.head_hand", 32'(if_dout), 32'hB4);
    for (int i = 0; i < 3; i++) cycle("post", 1'b0, 1'b1, 8'h00);

    // Full plus read+write: read wins, write refused.
    for (int i = 0; i < 5; i++) cycle("refill", 1'b1, 1'b0, 8'(8'hB0 + i));
    cycle("full_rw", 1'b1, 1'b1, 8'hEE);
    chk("full_rw.ndv_hand", 32'(if_num_data_valid), 32'd4);
    chk("full_rw.head_hand", 32'(if_dout), 32'hB1);
    for (int i = 0; i < 4; i++) cycle("drain2", 1'b0, 1'b1, 8'h00);

    // Empty plus read+write: write wins, no fall-through.
    cycle("empty_rw", 1'b1, 1'b1, 8'hC7);
    chk("empty_rw.dout_hand", 32'(if_dout), 32'hC7);
    chk("empty_rw.ndv_hand", 32'(if_num_data_valid), 32'd1);

`ifdef HLS_STREAM_FIFO_ERR_FLAGS_EN
    cycle("drain3", 1'b0, 1'b1, 8'h00);
    cycle("underflow", 1'b0, 1'b1, 8'h00);
    chk("underflow.set", 32'(if_underflow), 32'd1);
    tick();
    chk("underflow.sticky", 32'(if_underflow), 32'd1);
    if_err_clr = 1'b1; tick(); if_err_clr = 1'b0;
    chk("underflow.clr", 32'(if_underflow), 32'd0);
    for (int i = 0; i < 5; i++) cycle("errfill", 1'b1, 1'b0, 8'(8'hD0 + i));
    chk("overflow.pre", 32'(if_overflow), 32'd0);
    cycle("overflow", 1'b1, 1'b0, 8'hDF);
    chk("overflow.set", 32'(if_overflow), 32'd1);
`endif

    // Reset mid-traffic discards the accept in flight.
    if_write = 1'b1; if_write_ce = 1'b1; if_din = 8'h99; reset = 1'b1;
    tick();
    if_write = 1'b0; reset = 1'b0;
    q.delete(); m_cnt = 0;
    chk_status("mid_reset");
`ifdef HLS_STREAM_FIFO_ERR_FLAGS_EN
    chk("mid_reset.ovf", 32'(if_overflow), 32'd0);
`endif
    cycle("after_reset", 1'b1, 1'b0, 8'h5A);
    chk("after_reset.dout", 32'(if_dout), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
